axi_prot_checker: RTL and testbench

Passive, parametrised AXI3 protocol checker that monitors one master–slave port and reports violations as registered error flags and counters.
- Tracks handshake legality and payload stability on all five channels.
- Matches write-data bursts against AWLEN and read-data bursts against ARLEN, and counts outstanding transactions.
- Instantiated beside the master driver in the AXI env, with all AXI signals as inputs. It drives nothing onto the bus.

---
 rtl/axi_chk_pkg.sv | 47 ++++
 rtl/axi_chk_len_fifo.sv | 50 +++++
 rtl/axi_prot_checker.sv | 193 +++++++++++++++++++
 tb/tb_axi_prot_checker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_chk_pkg.sv
// Shared definitions for the AXI3 protocol checker: error bit indices, channel
// indices, AXI burst/response encodings and the burst-length helper.
package axi_chk_pkg;

  localparam int ERR_AW_DROP = 0;
  localparam int ERR_W_DROP  = 1;
  localparam int ERR_AR_DROP = 2;
  localparam int ERR_B_DROP  = 3;
  localparam int ERR_R_DROP  = 4;
  localparam int ERR_AW_UNST = 5;
  localparam int ERR_W_UNST  = 6;
  localparam int ERR_AR_UNST = 7;
  localparam int ERR_WLAST   = 8;
  localparam int ERR_RLAST   = 9;
  localparam int ERR_B_UNEXP = 10;
  localparam int ERR_R_UNEXP = 11;
  localparam int ERR_OVF     = 12;
  localparam int ERR_TIMEOUT = 13;
  localparam int ERR_NUM     = 14;

  // Channel order matches the VALID_DROP bit order.
  localparam int NCH   = 5;
  localparam int CH_AW = 0;
  localparam int CH_W  = 1;
  localparam int CH_AR = 2;
  localparam int CH_B  = 3;
  localparam int CH_R  = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  function automatic logic [4:0] beats(input logic [3:0] len);
    return {1'b0, len} + 5'd1;
  endfunction

endpackage

// File: rtl/axi_chk_len_fifo.sv
// Small synchronous FIFO holding 4-bit burst lengths / beat counts for the
// protocol checker. Pushes into a full FIFO and pops from an empty one are ignored.
module axi_chk_len_fifo #(
  parameter int  DEPTH = 8,
  parameter int  W     = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          aclk,
  input  logic          arst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge aclk) begin
    if (arst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/axi_prot_checker.sv
// Passive AXI3 protocol checker: handshake legality, payload stability, burst
// length matching and outstanding-transaction tracking, reported as error flags.
// Define AXI_CHK_TIMEOUT_EN to add per-channel VALID-without-READY watchdogs (bit 13).
module axi_prot_checker
  import axi_chk_pkg::*;
#(
  parameter int  ID_W      = 4,
  parameter int  ADDR_W    = 32,
  parameter int  DATA_W    = 32,
  parameter int  MAX_OUTST = 8,
  parameter int  TIMEOUT   = 256,
  parameter int  CNT_W     = 16,
  localparam int AXW       = ID_W + ADDR_W + 20,
  localparam int WW        = ID_W + DATA_W + DATA_W/8 + 3,
  localparam int BW        = ID_W + 4,
  localparam int RW        = ID_W + DATA_W + 5,
  localparam int OW        = $clog2(MAX_OUTST + 1)
) (
  input  logic               aclk,
  input  logic               arst,
  input  logic [AXW-1:0]     aw_bus,
  input  logic [WW-1:0]      w_bus,
  input  logic [BW-1:0]      b_bus,
  input  logic [AXW-1:0]     ar_bus,
  input  logic [RW-1:0]      r_bus,
  input  logic               clr_err,
  output logic [ERR_NUM-1:0] err_sticky,
  output logic [ERR_NUM-1:0] err_pulse,
  output logic [CNT_W-1:0]   err_count,
  output logic [OW-1:0]      wr_outst,
  output logic [OW-1:0]      rd_outst
);

  // Every bus carries {payload..., valid, ready} with ready in bit 0.
  logic [NCH-1:0] vld, rdy, hs, stall_q;
  assign vld = {r_bus[1], b_bus[1], ar_bus[1], w_bus[1], aw_bus[1]};
  assign rdy = {r_bus[0], b_bus[0], ar_bus[0], w_bus[0], aw_bus[0]};
  assign hs  = vld & rdy;

  logic [3:0] awlen, arlen;
  logic       wlast, rlast;
  assign awlen = aw_bus[19:16];
  assign arlen = ar_bus[19:16];
  assign wlast = w_bus[2];
  assign rlast = r_bus[2];

  logic [AXW-3:0] aw_q, ar_q;
  logic [WW-3:0]  w_q;

  always_ff @(posedge aclk) begin
    if (arst) begin
      stall_q <= '0;
      aw_q    <= '0;
      ar_q    <= '0;
      w_q     <= '0;
    end else begin
      stall_q <= vld & ~rdy;
      aw_q    <= aw_bus[AXW-1:2];
      ar_q    <= ar_bus[AXW-1:2];
      w_q     <= w_bus[WW-1:2];
    end
  end

  logic [2:0] unstable;
  assign unstable[0] = stall_q[CH_AW] & vld[CH_AW] & (aw_bus[AXW-1:2] != aw_q);
  assign unstable[1] = stall_q[CH_W]  & vld[CH_W]  & (w_bus[WW-1:2]   != w_q);
  assign unstable[2] = stall_q[CH_AR] & vld[CH_AR] & (ar_bus[AXW-1:2] != ar_q);

  // ---- write path ----
  logic          aw_full, aw_empty, wc_full, wc_empty, ar_full, ar_empty;
  logic [3:0]    aw_head, wc_head, ar_head;
  logic [OW-1:0] aw_occ, wc_occ;
  logic [3:0]    wbeat;
  logic [OW-1:0] wr_ready_cnt;
  logic          aw_block, aw_push, aw_ovf, wc_push, wc_ovf;
  logic          w_runaway, pair_pop, w_mis, b_unexp, b_ok;

  assign aw_block  = aw_full | (wr_outst == OW'(MAX_OUTST));
  assign aw_push   = hs[CH_AW] & ~aw_block;
  assign aw_ovf    = hs[CH_AW] & aw_block;
  assign wc_push   = hs[CH_W] & wlast;
  assign wc_ovf    = wc_push & wc_full;
  assign w_runaway = hs[CH_W] & ~wlast & (wbeat == 4'd15);
  assign pair_pop  = ~aw_empty & ~wc_empty;
  assign w_mis     = pair_pop & (beats(wc_head) != beats(aw_head));
  assign b_unexp   = hs[CH_B] & (wr_ready_cnt == '0);
  assign b_ok      = hs[CH_B] & ~b_unexp;

  // The beat-count FIFO stores beats-1 so a full 16-beat burst fits in 4 bits.
  axi_chk_len_fifo #(.DEPTH(MAX_OUTST), .W(4)) fifo_awlen (
    .aclk(aclk), .arst(arst), .push(aw_push), .pop(pair_pop), .din(awlen),
    .dout(aw_head), .full(aw_full), .empty(aw_empty), .count(aw_occ)
  );

  axi_chk_len_fifo #(.DEPTH(MAX_OUTST), .W(4)) fifo_wcnt (
    .aclk(aclk), .arst(arst), .push(wc_push), .pop(pair_pop), .din(wbeat),
    .dout(wc_head), .full(wc_full), .empty(wc_empty), .count(wc_occ)
  );

  always_ff @(posedge aclk) begin
    if (arst) begin
      wbeat        <= '0;
      wr_ready_cnt <= '0;
      wr_outst     <= '0;
    end else begin
      if (hs[CH_W]) wbeat <= (wlast || wbeat == 4'd15) ? 4'd0 : wbeat + 4'd1;
      wr_ready_cnt <= wr_ready_cnt + OW'(pair_pop) - OW'(b_ok);
      wr_outst     <= wr_outst + OW'(aw_push) - OW'(b_ok);
    end
  end

  // ---- read path (in-order across IDs) ----
  logic [3:0] rbeat;
  logic       ar_push, ar_ovf, r_unexp, r_act, r_last_exp, r_mis, r_pop;

  assign ar_push    = hs[CH_AR] & ~ar_full;
  assign ar_ovf     = hs[CH_AR] & ar_full;
  assign r_unexp    = hs[CH_R] & ar_empty;
  assign r_act      = hs[CH_R] & ~ar_empty;
  assign r_last_exp = (beats(rbeat) == beats(ar_head));
  assign r_mis      = r_act & (rlast ^ r_last_exp);
  assign r_pop      = r_act & (rlast | r_last_exp);

  axi_chk_len_fifo #(.DEPTH(MAX_OUTST), .W(4)) fifo_arlen (
    .aclk(aclk), .arst(arst), .push(ar_push), .pop(r_pop), .din(arlen),
    .dout(ar_head), .full(ar_full), .empty(ar_empty), .count(rd_outst)
  );

  always_ff @(posedge aclk) begin
    if (arst)       rbeat <= '0;
    else if (r_pop) rbeat <= '0;
    else if (r_act) rbeat <= rbeat + 4'd1;
  end

  // ---- optional watchdogs ----
  logic to_err;
`ifdef AXI_CHK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [NCH-1:0] to_hit;
  for (genvar c = 0; c < NCH; c++) begin : g_wd
    logic [TW-1:0] wd;
    // Saturates at TIMEOUT so each stall reports only once.
    always_ff @(posedge aclk) begin
      if (arst || !vld[c] || hs[c])  wd <= '0;
      else if (wd != TW'(TIMEOUT))   wd <= wd + TW'(1);
    end
    assign to_hit[c] = vld[c] & ~rdy[c] & (wd == TW'(TIMEOUT - 1));
  end
  assign to_err = |to_hit;
`else
  localparam int unused_timeout = TIMEOUT;
  assign to_err = 1'b0;
`endif

  // ---- error collection ----
  logic [ERR_NUM-1:0] err_now;
  always_comb begin
    err_now                      = '0;
    err_now[ERR_AW_DROP +: NCH]  = stall_q & ~vld;
    err_now[ERR_AW_UNST +: 3]    = unstable;
    err_now[ERR_WLAST]           = w_runaway | w_mis;
    err_now[ERR_RLAST]           = r_mis;
    err_now[ERR_B_UNEXP]         = b_unexp;
    err_now[ERR_R_UNEXP]         = r_unexp;
    err_now[ERR_OVF]             = aw_ovf | wc_ovf | ar_ovf;
    err_now[ERR_TIMEOUT]         = to_err;
  end

  localparam int SW = CNT_W + 1;
  logic [SW-1:0] cnt_sum;
  assign cnt_sum = {1'b0, err_count} + SW'($countones(err_now));

  always_ff @(posedge aclk) begin
    if (arst) begin
      err_pulse  <= '0;
      err_sticky <= '0;
      err_count  <= '0;
    end else begin
      err_pulse <= err_now;
      if (clr_err) begin
        err_sticky <= '0;
        err_count  <= '0;
      end else begin
        err_sticky <= err_sticky | err_now;
        err_count  <= cnt_sum[SW-1] ? '1 : cnt_sum[CNT_W-1:0];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{b_bus[BW-1:2], r_bus[RW-1:3], aw_occ, wc_occ};

endmodule

// File: tb/tb_axi_prot_checker.sv
// Scoreboard bench for axi_prot_checker: each driven cycle queues the expected
// err_pulse; a monitor pops and compares after every clock edge.
module tb_axi_prot_checker;
  import axi_chk_pkg::*;

  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32;
  localparam int MAX_OUTST = 8, TIMEOUT = 256, CNT_W = 16;
  localparam int OW = $clog2(MAX_OUTST + 1);
`ifdef AXI_CHK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic aclk = 1'b0;
  logic arst, clr_err;
  logic awvalid, awready, arvalid, arready, wvalid, wready, wlast;
  logic bvalid, bready, rvalid, rready, rlast;
  logic [3:0]  awlen, arlen;
  logic [31:0] awaddr, araddr, wdata, rdata;

  logic [ID_W+ADDR_W+19:0]         aw_bus, ar_bus;
  logic [ID_W+DATA_W+DATA_W/8+2:0] w_bus;
  logic [ID_W+3:0]                 b_bus;
  logic [ID_W+DATA_W+4:0]          r_bus;
  logic [ERR_NUM-1:0]              err_sticky, err_pulse;
  logic [CNT_W-1:0]                err_count;
  logic [OW-1:0]                   wr_outst, rd_outst;

  assign aw_bus = {4'h1, awaddr, awlen, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0, awvalid, awready};
  assign ar_bus = {4'h2, araddr, arlen, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0, arvalid, arready};
  assign w_bus  = {4'h1, wdata, 4'hF, wlast, wvalid, wready};
  assign b_bus  = {4'h1, 2'b00, bvalid, bready};
  assign r_bus  = {4'h2, rdata, 2'b00, rlast, rvalid, rready};

  axi_prot_checker #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MAX_OUTST(MAX_OUTST), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .aclk(aclk), .arst(arst), .aw_bus(aw_bus), .w_bus(w_bus), .b_bus(b_bus),
    .ar_bus(ar_bus), .r_bus(r_bus), .clr_err(clr_err), .err_sticky(err_sticky),
    .err_pulse(err_pulse), .err_count(err_count), .wr_outst(wr_outst), .rd_outst(rd_outst)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    string              tag;
    logic [ERR_NUM-1:0] pulse;
  } exp_t;

  exp_t  sbq[$];
  int    n_chk = 0, n_pass = 0;
  string cur_tag = "reset";

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [ERR_NUM-1:0] em(input int b);
    logic [ERR_NUM-1:0] m;
    m    = '0;
    m[b] = 1'b1;
    return m;
  endfunction

  // Inputs change at negedge; the pushed value is err_pulse after the next posedge.
  task automatic tick(input logic [ERR_NUM-1:0] e);
    exp_t x;
    x.tag   = cur_tag;
    x.pulse = e;
    sbq.push_back(x);
    @(negedge aclk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0);
  endtask

  task automatic aw_hs(input logic [3:0] len, input logic [ERR_NUM-1:0] e);
    awvalid = 1'b1; awready = 1'b1; awlen = len;
    tick(e);
    awvalid = 1'b0; awready = 1'b0;
  endtask

  task automatic ar_hs(input logic [3:0] len, input logic [ERR_NUM-1:0] e);
    arvalid = 1'b1; arready = 1'b1; arlen = len;
    tick(e);
    arvalid = 1'b0; arready = 1'b0;
  endtask

  task automatic w_beat(input logic last, input logic [ERR_NUM-1:0] e);
    wvalid = 1'b1; wready = 1'b1; wlast = last; wdata = $urandom;
    tick(e);
    wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
  endtask

  task automatic r_beat(input logic last, input logic [ERR_NUM-1:0] e);
    rvalid = 1'b1; rready = 1'b1; rlast = last; rdata = $urandom;
    tick(e);
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
  endtask

  task automatic b_hs(input logic [ERR_NUM-1:0] e);
    bvalid = 1'b1; bready = 1'b1;
    tick(e);
    bvalid = 1'b0; bready = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (sbq.size() != 0) begin
        exp_t x;
        x = sbq.pop_front();
        chk({"pulse_", x.tag}, 32'(err_pulse), 32'(x.pulse));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    arst = 1'b1; clr_err = 1'b0;
    awvalid = 0; awready = 0; arvalid = 0; arready = 0; wvalid = 0; wready = 0; wlast = 0;
    bvalid = 0; bready = 0; rvalid = 0; rready = 0; rlast = 0;
    awlen = 0; arlen = 0; awaddr = 32'h0; araddr = 32'h200; wdata = 0; rdata = 0;
    @(negedge aclk);
    idle(3);
    arst = 1'b0;
    chk("rst_sticky", 32'(err_sticky), 0);
    chk("rst_count", 32'(err_count), 0);
    chk("rst_wr_outst", 32'(wr_outst), 0);
    chk("rst_rd_outst", 32'(rd_outst), 0);

    cur_tag = "legal_wr";
    aw_hs(4'd3, '0);
    chk("legal_wr_outst1", 32'(wr_outst), 1);
    for (int i = 0; i < 3; i++) w_beat(1'b0, '0);
    w_beat(1'b1, '0);
    idle(1);
    b_hs('0);
    chk("legal_wr_outst0", 32'(wr_outst), 0);

    cur_tag = "w_first";
    for (int i = 0; i < 3; i++) w_beat(1'b0, '0);
    w_beat(1'b1, '0);
    idle(2);
    aw_hs(4'd3, '0);
    chk("w_first_outst1", 32'(wr_outst), 1);
    idle(1);
    b_hs('0);
    chk("w_first_outst0", 32'(wr_outst), 0);
    chk("w_first_count", 32'(err_count), 0);

    cur_tag = "wlast_short";
    aw_hs(4'd3, '0);
    w_beat(1'b0, '0);
    w_beat(1'b0, '0);
    w_beat(1'b1, '0);
    tick(em(ERR_WLAST));
    chk("wlast_short_count", 32'(err_count), 1);
    chk("wlast_short_sticky", 32'(err_sticky), 32'(em(ERR_WLAST)));
    b_hs('0);
    chk("wlast_short_outst", 32'(wr_outst), 0);
    clr_err = 1'b1;
    tick('0);
    clr_err = 1'b0;
    chk("clr1_count", 32'(err_count), 0);

    cur_tag = "aw_unstable";
    awlen = 4'd0; awaddr = 32'h100; awvalid = 1'b1; awready = 1'b0;
    tick('0);
    awaddr = 32'h104;
    tick(em(ERR_AW_UNST));
    chk("aw_unst_sticky", 32'(err_sticky), 32'(em(ERR_AW_UNST)));
    chk("aw_unst_count", 32'(err_count), 1);
    clr_err = 1'b1; awready = 1'b1;
    tick('0);
    clr_err = 1'b0; awvalid = 1'b0; awready = 1'b0;
    chk("clr2_sticky", 32'(err_sticky), 0);
    chk("clr2_count", 32'(err_count), 0);
    chk("aw_unst_outst", 32'(wr_outst), 1);
    w_beat(1'b1, '0);
    idle(1);
    b_hs('0);

    cur_tag = "b_unexp";
    b_hs(em(ERR_B_UNEXP));
    chk("b_unexp_sticky", 32'(err_sticky), 32'(em(ERR_B_UNEXP)));

    cur_tag = "w_drop";
    wvalid = 1'b1; wready = 1'b0;
    tick('0);
    wvalid = 1'b0;
    tick(em(ERR_W_DROP));

    cur_tag = "w_runaway";
    for (int i = 1; i <= 16; i++) w_beat(1'b0, (i == 16) ? em(ERR_WLAST) : '0);
    chk("runaway_outst", 32'(wr_outst), 0);

    cur_tag = "rd";
    ar_hs(4'd1, '0);
    r_beat(1'b0, '0);
    r_beat(1'b1, '0);
    chk("rd_ok_outst", 32'(rd_outst), 0);
    ar_hs(4'd1, '0);
    r_beat(1'b1, em(ERR_RLAST));
    chk("rd_early_outst", 32'(rd_outst), 0);
    ar_hs(4'd0, '0);
    r_beat(1'b0, em(ERR_RLAST));
    chk("rd_missing_outst", 32'(rd_outst), 0);
    r_beat(1'b1, em(ERR_R_UNEXP));

    cur_tag = "ar_ovf";
    for (int i = 1; i <= 9; i++) ar_hs(4'd0, (i == 9) ? em(ERR_OVF) : '0);
    chk("ovf_rd_outst", 32'(rd_outst), MAX_OUTST);
    chk("ovf_count", 32'(err_count), 7);
    chk("ovf_sticky", 32'(err_sticky),
        32'(em(ERR_B_UNEXP) | em(ERR_W_DROP) | em(ERR_WLAST) | em(ERR_RLAST) |
            em(ERR_R_UNEXP) | em(ERR_OVF)));
    for (int i = 0; i < 8; i++) r_beat(1'b1, '0);
    chk("drain_rd_outst", 32'(rd_outst), 0);

    cur_tag = "timeout";
    arvalid = 1'b1; arready = 1'b0; arlen = 4'd0;
    for (int i = 1; i <= 300; i++) tick((TO_EN && i == TIMEOUT) ? em(ERR_TIMEOUT) : '0);
    arready = 1'b1;
    tick('0);
    arvalid = 1'b0; arready = 1'b0;
    r_beat(1'b1, '0);
    chk("timeout_count", 32'(err_count), TO_EN ? 8 : 7);

    cur_tag = "rst_mid";
    ar_hs(4'd3, '0);
    r_beat(1'b0, '0);
    r_beat(1'b0, '0);
    arst = 1'b1;
    idle(2);
    arst = 1'b0;
    chk("rst_mid_rd_outst", 32'(rd_outst), 0);
    chk("rst_mid_sticky", 32'(err_sticky), 0);
    chk("rst_mid_count", 32'(err_count), 0);
    r_beat(1'b1, em(ERR_R_UNEXP));
    chk("rst_mid_count1", 32'(err_count), 1);

    idle(2);
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
